// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. A single full_adder is time-shared across a
// WIDTH-bit addition, one bit per clock, LSB first. Operands live in right-
// shifting registers, the running carry lives in a flip-flop, and each sum bit
// is shifted into the MSB of a result register so that after WIDTH steps the
// result register holds the complete sum in natural bit order.
//
// Handshake: start is accepted in IDLE or DONE. busy is high for the WIDTH
// RUN cycles, done pulses for the single DONE cycle, and sum/cout are
// registered and held until the next completion (or reset).
//
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input. With sub=1 the
// B register is loaded with ~b and the carry with 1, so sum = a - b and
// cout=1 means "no borrow". Without the macro there is no 'sub' port.
//
// Ports:
//   clk    in   1      system clock, rising-edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      begin an addition (accepted in IDLE/DONE)
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   cin    in   1      carry-in, sampled on the accepting edge
//   sub    in   1      subtract select (SERIAL_ADD_SUB_EN builds only)
//   busy   out  1      high while RUN
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  registered result
//   cout   out  1      registered final carry-out
//
// Also contains the full_adder / half_adder leaf cells used by the datapath.
// ----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must index 0..WIDTH-1; a 1-bit counter is kept even for WIDTH=1.
    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Shared datapath cell
    logic fa_s;
    logic fa_cout;

    full_adder u_full_adder (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Values loaded into the B register and carry flop on an accepted start.
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: a + ~b + 1. cin is ignored when subtracting.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // Result register after this step's bit enters at the MSB. Written with
    // shifts rather than a part-select so it stays legal for WIDTH=1.
    logic [WIDTH-1:0] res_shift;
    assign res_shift = (res_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            // DONE accepts start exactly like IDLE, giving back-to-back ops.
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end

            StRun: begin
                res_sr_d = res_shift;
                carry_d  = fa_cout;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Last bit: publish the result; start is ignored in RUN.
                    state_d = StDone;
                    sum_d   = res_shift;
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // All outputs come straight from flops: no input-to-output comb path.
    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// ----------------------------------------------------------------------------
// full_adder: one-bit full adder built from two half adders.
//   a, b, cin in; s (sum bit), cout (carry) out.
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .a (s1),
        .b (cin),
        .s (s),
        .c (c2)
    );

    assign cout = c1 | c2;

endmodule

// ----------------------------------------------------------------------------
// half_adder: one-bit half adder.
//   a, b in; s (sum bit), c (carry) out.
// ----------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    // WIDTH=8 instance
    logic       start = 1'b0;
    logic [7:0] a     = '0;
    logic [7:0] b     = '0;
    logic       cin   = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic [0:0] a1     = '0;
    logic [0:0] b1     = '0;
    logic       cin1   = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

`ifdef SERIAL_ADD_SUB_EN
    logic       sub  = 1'b0;
    logic       sub1 = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Last result the main DUT should be holding.
    logic [7:0] prev_sum  = '0;
    logic       prev_cout = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Issue one operation from a negedge where the DUT is in IDLE or DONE and
    // return at the negedge where done is seen. Expected result is plain
    // arithmetic on the operands.
    task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic sv, input string name);
        logic [8:0] exp;
        int         busy_cnt;
        int         lat;
        bit         seen;
        if (sv) exp = {1'b0, av} + {1'b0, ~bv} + 9'd1;
        else    exp = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
`ifdef SERIAL_ADD_SUB_EN
        sub   = sv;
`endif
        @(posedge clk);
        #1;
        // Drop start and scramble operands: the DUT must not resample them.
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        busy_cnt = 0;
        lat      = 0;
        seen     = 1'b0;
        for (int n = 1; n <= 3 * W + 4 && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end else if (busy === 1'b1) begin
                busy_cnt++;
                checks++;
                if ({cout, sum} !== {prev_cout, prev_sum}) begin
                    errors++;
                    $display("FAIL %s hold_during_run: got %h expected %h", name,
                             {cout, sum}, {prev_cout, prev_sum});
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: got no done expected done after %0d cycles",
                     name, W + 1);
        end else begin
            checks++;
            if (lat !== W + 1) begin
                errors++;
                $display("FAIL %s done_latency: got %0d expected %0d", name, lat, W + 1);
            end
            checks++;
            if (busy_cnt !== W || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_cycles: got %0d (busy at done=%b) expected %0d (0)",
                         name, busy_cnt, busy, W);
            end
            checks++;
            if ({cout, sum} !== exp) begin
                errors++;
                $display("FAIL %s result: got cout=%b sum=%h expected cout=%b sum=%h",
                         name, cout, sum, exp[8], exp[7:0]);
            end
        end
        prev_sum  = exp[7:0];
        prev_cout = exp[8];
    endtask

    // Idle cycles with start low: no busy, no done, result held.
    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || {cout, sum} !== {prev_cout, prev_sum}) begin
                errors++;
                $display("FAIL %s idle: got busy=%b done=%b res=%h expected 0 0 %h", name,
                         busy, done, {cout, sum}, {prev_cout, prev_sum});
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
                     busy, done, sum, cout);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_w1: got busy=%b done=%b sum=%b cout=%b expected 0 0 0 0",
                     busy1, done1, sum1, cout1);
        end
        rst_n = 1'b1;
        idle_cycles(3, "post_reset");
    endtask

    task automatic test_directed();
        do_add(8'h5A, 8'h3C, 1'b0, 1'b0, "add_5a_3c");
        idle_cycles(1, "add_5a_3c");
        do_add(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        idle_cycles(1, "add_ff_01");
        do_add(8'hFF, 8'h00, 1'b1, 1'b0, "add_ff_00_c1");
        idle_cycles(2, "add_ff_00_c1");
    endtask

    task automatic test_start_held();
        int busy_cnt;
        int lat;
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'hFF;
        // First op: start stays high throughout RUN.
        busy_cnt = 0;
        lat      = 0;
        for (int n = 1; n <= 3 * W && lat == 0; n++) begin
            @(negedge clk);
            if (done === 1'b1) lat = n;
            else if (busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (lat !== W + 1 || busy_cnt !== W) begin
            errors++;
            $display("FAIL held_first_timing: got lat=%0d busy=%0d expected %0d %0d",
                     lat, busy_cnt, W + 1, W);
        end
        checks++;
        if ({cout, sum} !== 9'h046) begin
            errors++;
            $display("FAIL held_first_result: got %h expected 046", {cout, sum});
        end
        // Held start is accepted in the DONE cycle.
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_cnt = 0;
        lat      = 0;
        for (int n = 1; n <= 3 * W && lat == 0; n++) begin
            @(negedge clk);
            if (done === 1'b1) lat = n;
            else if (busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (lat !== W + 1 || busy_cnt !== W) begin
            errors++;
            $display("FAIL held_second_timing: got lat=%0d busy=%0d expected %0d %0d",
                     lat, busy_cnt, W + 1, W);
        end
        checks++;
        if ({cout, sum} !== 9'h1FE) begin
            errors++;
            $display("FAIL held_second_result: got %h expected 1fe", {cout, sum});
        end
        prev_sum  = 8'hFE;
        prev_cout = 1'b1;
        idle_cycles(2, "held");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_add(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "b2b");
        end
        idle_cycles(1, "b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            do_add(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");
            idle_cycles(int'($urandom_range(0, 3)), "rand");
        end
        idle_cycles(1, "rand");
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_busy_before: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: got busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
                     busy, done, sum, cout);
        end
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_done: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
        rst_n = 1'b1;
        idle_cycles(W + 2, "after_reset");
        do_add(8'h01, 8'h01, 1'b0, 1'b0, "after_reset_01_01");
        idle_cycles(1, "after_reset_01_01");
    endtask

    task automatic test_width1();
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            exp    = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            start1 = 1'b1;
            a1     = i[2];
            b1     = i[1];
            cin1   = i[0];
            @(posedge clk);
            #1;
            start1 = 1'b0;
            a1     = 1'($urandom);
            b1     = 1'($urandom);
            @(negedge clk);
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_run_%0d: got busy=%b done=%b expected 1 0", i, busy1, done1);
            end
            @(negedge clk);
            checks++;
            if (busy1 !== 1'b0 || done1 !== 1'b1 || {cout1, sum1} !== exp) begin
                errors++;
                $display("FAIL w1_done_%0d: got busy=%b done=%b res=%b expected 0 1 %b",
                         i, busy1, done1, {cout1, sum1}, exp);
            end
            @(negedge clk);
            checks++;
            if (done1 !== 1'b0 || {cout1, sum1} !== exp) begin
                errors++;
                $display("FAIL w1_hold_%0d: got done=%b res=%b expected 0 %b",
                         i, done1, {cout1, sum1}, exp);
            end
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        do_add(8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");
        idle_cycles(1, "sub_10_01");
        do_add(8'h01, 8'h02, 1'b1, 1'b1, "sub_01_02");
        idle_cycles(1, "sub_01_02");
        for (int i = 0; i < 10; i++) begin
            do_add(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "sub_rand");
        end
        idle_cycles(1, "sub_rand");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_start_held();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_width1();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
